jt7759_adpcm_mc: RTL and testbench
==================================

JT7759_ADPCM_MC -- requirements
Module: jt7759_adpcm_mc

Interface
REQ-001 Parameters SHALL be: CH, default 2, channel count (1..8); OW, default 9, output sample width (9..16).
REQ-002 Port rst  input  1  asynchronous, active-high reset.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port cen  input  1  decode-slot enable; one channel serviced per cen-high cycle.
REQ-005 Port cendec  input  1  output-update strobe; sound outputs latch only on cendec-high cycles.
REQ-006 Port din  input  4  ADPCM nibble.
REQ-007 Port din_ch  input  max(1,clog2(CH))  target channel for din.
REQ-008 Port din_we  input  1  nibble write strobe.
REQ-009 Port clr  input  CH  per-channel restart pulse.
REQ-010 Port busy  output  CH  channel holds an unconsumed nibble.
REQ-011 Port muted  output  CH  channel has produced no sample since reset/clr.
REQ-012 Port sound_ch  output  CH*OW  per-channel signed samples, channel 0 in LSBs.
REQ-013 Port sound  output  OW  saturated mix of all unmuted channels.

Function
REQ-014 Per channel: 9-bit signed signal, 4-bit state, pending flag, 4-bit nibble buffer.
REQ-015 din_we with busy[din_ch]=0 SHALL store din and set pending; busy rises next cycle; din_we with busy[din_ch]=1 or din_ch>=CH SHALL be ignored.
REQ-016 Round-robin pointer 0..CH-1 SHALL advance by one, wrapping CH-1->0, on each cen-high cycle; idle when cen low.
REQ-017 On cen-high, pointed channel with pending=1 SHALL decode: signal += step[state][nibble], state += dstate[nibble], pending cleared, muted cleared, all at the same edge.
REQ-018 dstate = {-1,-1,0,0,1,2,2,3} for nibbles 0-7, repeated for 8-15; step row 0 = {0,0,1,2,3,5,7,10} for 0-7, negated for 8-15; rows 1-15 per uPD7759 datasheet table, stored as ROM.
REQ-019 Signal SHALL saturate to -256..255; state SHALL clamp to 0..15.
REQ-020 Worst-case nibble-to-decode latency SHALL be CH cen pulses.
REQ-021 Write and decode of same channel in same cycle: decode consumes old nibble; write ignored (busy was 1).
REQ-022 clr[i] SHALL zero signal and state, clear pending, set muted[i]; clr wins over simultaneous write or decode of channel i.
REQ-023 On cendec-high, sound_ch slot i SHALL load signal_i sign-extended to OW and shifted left OW-9 bits; muted channels load 0.
REQ-024 sound SHALL be the full-precision sum of sound_ch values being loaded, saturated to OW-bit signed range, loaded on the same cendec edge.
REQ-025 One decode datapath shared by all channels (time-multiplexed); no per-channel adders.

Reset
REQ-026 rst SHALL asynchronously set signal=0, state=0, pending=0, pointer=0, busy=0, muted=all ones, sound_ch=0, sound=0.
REQ-027 Reset mid-decode SHALL discard pending nibbles; first cen after release services channel 0.

Configuration
REQ-028 Macro JT7759_MIX_EN: defined -> sound per REQ-024; undefined -> sound held 0, mix adder/saturator not synthesised, sound_ch unaffected.

Verification
REQ-029 Reset, ch0 nibble 7, one cen -> ch0 signal 10, state 3, muted[0]=0; next cendec -> sound_ch[0]=10 (OW=9).
REQ-030 Reset, ch1 nibble 15, two cen -> ch1 signal -10, state 3; ch0 unchanged, muted[0]=1.
REQ-031 Nibble 7 repeated 40 times on ch0 -> signal stops at 255, state stops at 15.
REQ-032 Second din_we to ch0 while busy[0]=1 -> ignored; exactly one decode occurs.
REQ-033 CH=2, OW=9, both channels at 200, JT7759_MIX_EN defined -> sound=255; undefined -> sound=0.
REQ-034 clr[0] asserted same cycle as ch0 decode -> signal 0, state 0, muted[0]=1, busy[0]=0.

Source files
------------

// File: rtl/jt7759_adpcm_mc.sv
// Multi-channel uPD7759-style ADPCM decoder: one shared decode datapath serves the channels round-robin.
// Define JT7759_MIX_EN to build the saturated mix output `sound`; without it `sound` stays 0.
module jt7759_adpcm_mc #(
    parameter  int CH = 2,
    parameter  int OW = 9,
    localparam int PW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             cen,
    input  logic             cendec,
    input  logic [3:0]       din,
    input  logic [PW-1:0]    din_ch,
    input  logic             din_we,
    input  logic [CH-1:0]    clr,
    output logic [CH-1:0]    busy,
    output logic [CH-1:0]    muted,
    output logic [CH*OW-1:0] sound_ch,
    output logic [OW-1:0]    sound
);

    // Step magnitudes for nibble[2:0]; nibble[3] selects the negated half of each row.
    localparam logic [7:0] STEP_ROM [16][8] = '{
        '{8'd0, 8'd0,  8'd1,  8'd2,  8'd3,  8'd5,   8'd7,   8'd10 },
        '{8'd0, 8'd1,  8'd2,  8'd3,  8'd4,  8'd6,   8'd8,   8'd13 },
        '{8'd0, 8'd1,  8'd2,  8'd4,  8'd5,  8'd7,   8'd10,  8'd15 },
        '{8'd0, 8'd1,  8'd3,  8'd4,  8'd6,  8'd9,   8'd13,  8'd19 },
        '{8'd0, 8'd2,  8'd3,  8'd5,  8'd8,  8'd11,  8'd15,  8'd23 },
        '{8'd0, 8'd2,  8'd4,  8'd7,  8'd10, 8'd14,  8'd19,  8'd29 },
        '{8'd0, 8'd3,  8'd5,  8'd8,  8'd12, 8'd16,  8'd22,  8'd33 },
        '{8'd1, 8'd4,  8'd7,  8'd10, 8'd15, 8'd20,  8'd29,  8'd43 },
        '{8'd1, 8'd4,  8'd8,  8'd13, 8'd18, 8'd25,  8'd35,  8'd53 },
        '{8'd1, 8'd6,  8'd10, 8'd16, 8'd22, 8'd31,  8'd43,  8'd64 },
        '{8'd2, 8'd7,  8'd12, 8'd19, 8'd27, 8'd37,  8'd51,  8'd76 },
        '{8'd2, 8'd9,  8'd16, 8'd24, 8'd34, 8'd46,  8'd64,  8'd96 },
        '{8'd3, 8'd11, 8'd19, 8'd29, 8'd41, 8'd57,  8'd79,  8'd117},
        '{8'd4, 8'd13, 8'd24, 8'd36, 8'd50, 8'd69,  8'd96,  8'd143},
        '{8'd4, 8'd16, 8'd29, 8'd44, 8'd62, 8'd85,  8'd118, 8'd175},
        '{8'd6, 8'd20, 8'd36, 8'd54, 8'd76, 8'd106, 8'd147, 8'd222}
    };

    logic signed [8:0] sig [CH];
    logic        [3:0] st  [CH];
    logic        [3:0] nib [CH];
    logic     [CH-1:0] pend;
    logic     [PW-1:0] ptr;

    logic signed [8:0] cur_sig, next_sig;
    logic        [3:0] cur_st, cur_nib, next_st;
    logic        [7:0] mag;
    logic signed [9:0] delta, sum;
    logic signed [2:0] dst;
    logic signed [5:0] sst;

    assign busy = pend;

    always_comb begin
        cur_sig = '0;
        cur_st  = '0;
        cur_nib = '0;
        for (int i = 0; i < CH; i++) begin
            if (ptr == PW'(i)) begin
                cur_sig = sig[i];
                cur_st  = st[i];
                cur_nib = nib[i];
            end
        end
        mag   = STEP_ROM[cur_st][cur_nib[2:0]];
        delta = cur_nib[3] ? -$signed({2'b00, mag}) : $signed({2'b00, mag});
        sum   = 10'(cur_sig) + delta;
        if (sum > 10'sd255)
            next_sig = 9'sd255;
        else if (sum < -10'sd256)
            next_sig = -9'sd256;
        else
            next_sig = sum[8:0];
        case (cur_nib[2:0])
            3'd0, 3'd1: dst = -3'sd1;
            3'd2, 3'd3: dst = 3'sd0;
            3'd4:       dst = 3'sd1;
            3'd5, 3'd6: dst = 3'sd2;
            default:    dst = 3'sd3;
        endcase
        sst = $signed({2'b00, cur_st}) + 6'(dst);
        if (sst < 6'sd0)
            next_st = 4'd0;
        else if (sst > 6'sd15)
            next_st = 4'd15;
        else
            next_st = sst[3:0];
    end

    // Priority per channel: clear, then decode, then accepting a new nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            pend  <= '0;
            muted <= '1;
            for (int i = 0; i < CH; i++) begin
                sig[i] <= '0;
                st[i]  <= '0;
                nib[i] <= '0;
            end
        end else begin
            if (cen)
                ptr <= (ptr == PW'(CH - 1)) ? '0 : ptr + 1'b1;
            for (int i = 0; i < CH; i++) begin
                if (clr[i]) begin
                    sig[i]   <= '0;
                    st[i]    <= '0;
                    pend[i]  <= 1'b0;
                    muted[i] <= 1'b1;
                end else if (cen && ptr == PW'(i) && pend[i]) begin
                    sig[i]   <= next_sig;
                    st[i]    <= next_st;
                    pend[i]  <= 1'b0;
                    muted[i] <= 1'b0;
                end else if (din_we && din_ch == PW'(i) && !pend[i]) begin
                    nib[i]  <= din;
                    pend[i] <= 1'b1;
                end
            end
        end
    end

    logic signed [OW-1:0] ld [CH];
    logic        [OW-1:0] mix;

    always_comb begin
        for (int i = 0; i < CH; i++)
            ld[i] = muted[i] ? '0 : (OW'(sig[i]) <<< (OW - 9));
    end

`ifdef JT7759_MIX_EN
    localparam int SW = OW + 4;
    localparam logic signed [SW-1:0] SMAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    logic signed [SW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < CH; i++)
            acc = acc + SW'(ld[i]);
        if (acc > SMAX)
            mix = SMAX[OW-1:0];
        else if (acc < SMIN)
            mix = SMIN[OW-1:0];
        else
            mix = acc[OW-1:0];
    end
`else
    assign mix = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sound_ch <= '0;
            sound    <= '0;
        end else if (cendec) begin
            for (int i = 0; i < CH; i++)
                sound_ch[i*OW +: OW] <= ld[i];
            sound <= mix;
        end
    end

endmodule

// File: tb/tb_jt7759_adpcm_mc.sv
// Directed bench for jt7759_adpcm_mc (CH=2, OW=9); mix expectations follow JT7759_MIX_EN.
module tb_jt7759_adpcm_mc;
    localparam int CH = 2;
    localparam int OW = 9;
    localparam int PW = 1;

    logic             rst, clk, cen, cendec, din_we;
    logic [3:0]       din;
    logic [PW-1:0]    din_ch;
    logic [CH-1:0]    clr, busy, muted;
    logic [CH*OW-1:0] sound_ch;
    logic [OW-1:0]    sound;

    int n_checks = 0;
    int n_errors = 0;
    int tb_ptr   = 0;

    jt7759_adpcm_mc #(.CH(CH), .OW(OW)) dut (
        .rst(rst), .clk(clk), .cen(cen), .cendec(cendec),
        .din(din), .din_ch(din_ch), .din_we(din_we), .clr(clr),
        .busy(busy), .muted(muted), .sound_ch(sound_ch), .sound(sound)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] pk(input int c1, input int c0);
        return {9'(c1), 9'(c0)};
    endfunction

    function automatic logic [8:0] exp_mix(input int v);
`ifdef JT7759_MIX_EN
        return 9'(v);
`else
        return 9'(0 * v);
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tb_ptr = 0;
    endtask

    task automatic write_nib(input int ch, input logic [3:0] n);
        @(negedge clk);
        din_ch = PW'(ch);
        din    = n;
        din_we = 1'b1;
        @(negedge clk);
        din_we = 1'b0;
    endtask

    task automatic pulse_cen(input int k);
        repeat (k) begin
            @(negedge clk);
            cen = 1'b1;
            @(negedge clk);
            cen = 1'b0;
            tb_ptr = (tb_ptr + 1) % CH;
        end
    endtask

    task automatic latch();
        @(negedge clk);
        cendec = 1'b1;
        @(negedge clk);
        cendec = 1'b0;
    endtask

    // Write a nibble and give exactly enough cen pulses for the pointer to reach that channel.
    task automatic feed(input int ch, input logic [3:0] n);
        write_nib(ch, n);
        pulse_cen(((ch - tb_ptr + CH) % CH) + 1);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; cendec = 1'b0; din_we = 1'b0;
        din = '0; din_ch = '0; clr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(2'b00));
        chk("rst_muted", 32'(muted), 32'(2'b11));
        chk("rst_sound_ch", 32'(sound_ch), 32'(pk(0, 0)));
        chk("rst_sound", 32'(sound), 32'(9'd0));

        // ch0 nibble 7 from state 0 -> +10, state 3
        write_nib(0, 4'd7);
        chk("ch0_busy_after_write", 32'(busy), 32'(2'b01));
        pulse_cen(1);
        chk("ch0_busy_after_dec", 32'(busy), 32'(2'b00));
        chk("ch0_muted_after_dec", 32'(muted), 32'(2'b10));
        chk("sound_ch_before_cendec", 32'(sound_ch), 32'(pk(0, 0)));
        latch();
        chk("ch0_sig10", 32'(sound_ch), 32'(pk(0, 10)));
        chk("mix_10", 32'(sound), 32'(exp_mix(10)));
        feed(0, 4'd7);
        latch();
        chk("ch0_state3_step19", 32'(sound_ch), 32'(pk(0, 29)));

        // ch1 nibble 15 needs two cen pulses from pointer 0
        do_reset();
        write_nib(1, 4'd15);
        pulse_cen(1);
        chk("ch1_not_yet", 32'(busy), 32'(2'b10));
        pulse_cen(1);
        chk("ch1_busy_done", 32'(busy), 32'(2'b00));
        chk("ch1_muted", 32'(muted), 32'(2'b01));
        latch();
        chk("ch1_sig_m10", 32'(sound_ch), 32'(pk(-10, 0)));
        chk("mix_m10", 32'(sound), 32'(exp_mix(-10)));
        feed(1, 4'd15);
        latch();
        chk("ch1_state3_m29", 32'(sound_ch), 32'(pk(-29, 0)));
        chk("mix_m29", 32'(sound), 32'(exp_mix(-29)));

        // Second write while busy is dropped
        do_reset();
        write_nib(0, 4'd7);
        write_nib(0, 4'd12);
        chk("busy_hold", 32'(busy), 32'(2'b01));
        pulse_cen(3);
        chk("busy_clear_once", 32'(busy), 32'(2'b00));
        latch();
        chk("single_decode", 32'(sound_ch), 32'(pk(0, 10)));

        // Positive saturation, then state 15 shows up as a step of 6
        repeat (40) feed(0, 4'd7);
        latch();
        chk("ch0_sat_255", 32'(sound_ch), 32'(pk(0, 255)));
        feed(0, 4'd8);
        latch();
        chk("ch0_state15", 32'(sound_ch), 32'(pk(0, 249)));
        repeat (40) feed(1, 4'd7);
        latch();
        chk("both_high", 32'(sound_ch), 32'(pk(255, 249)));
        chk("mix_sat_pos", 32'(sound), 32'(exp_mix(255)));
        repeat (40) begin
            feed(0, 4'd15);
            feed(1, 4'd15);
        end
        latch();
        chk("both_sat_neg", 32'(sound_ch), 32'(pk(-256, -256)));
        chk("mix_sat_neg", 32'(sound), 32'(exp_mix(-256)));

        // clr beats a same-cycle decode (ch0) and a same-cycle write (ch1)
        do_reset();
        feed(0, 4'd7);
        write_nib(0, 4'd7);
        pulse_cen(1);
        @(negedge clk);
        cen = 1'b1; clr = 2'b11;
        din_ch = 1'b1; din = 4'd7; din_we = 1'b1;
        @(negedge clk);
        cen = 1'b0; clr = 2'b00; din_we = 1'b0;
        tb_ptr = (tb_ptr + 1) % CH;
        chk("clr_busy", 32'(busy), 32'(2'b00));
        chk("clr_muted", 32'(muted), 32'(2'b11));
        latch();
        chk("clr_sound_ch", 32'(sound_ch), 32'(pk(0, 0)));
        feed(0, 4'd7);
        latch();
        chk("clr_state0", 32'(sound_ch), 32'(pk(0, 10)));

        // Reset discards a pending nibble and returns the pointer to channel 0
        write_nib(1, 4'd7);
        chk("pre_rst_busy", 32'(busy), 32'(2'b10));
        do_reset();
        @(negedge clk);
        chk("rst2_busy", 32'(busy), 32'(2'b00));
        chk("rst2_muted", 32'(muted), 32'(2'b11));
        chk("rst2_sound_ch", 32'(sound_ch), 32'(pk(0, 0)));
        write_nib(1, 4'd7);
        pulse_cen(1);
        chk("rst2_ptr_at0", 32'(busy), 32'(2'b10));
        pulse_cen(1);
        chk("rst2_ch1_done", 32'(busy), 32'(2'b00));
        latch();
        chk("rst2_ch1_sig", 32'(sound_ch), 32'(pk(10, 0)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
